// File: rtl/rotary_accumulator.sv
// Rotary position accumulator: bounded value with speed-based acceleration.
// Ports: CLK/RST_N, i_cnt/i_cnt_cw/i_cnt_err/i_clear in; o_value/o_changed/o_at_limit/o_err_count out.
module rotary_accumulator #(
  parameter int WIDTH        = 8,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 255,
  parameter int WRAP         = 1,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_LEVELS = 3,
  parameter int ERR_WIDTH    = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 i_cnt,
  input  logic                 i_cnt_cw,
  input  logic                 i_cnt_err,
  input  logic                 i_clear,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_changed,
  output logic                 o_at_limit,
  output logic [ERR_WIDTH-1:0] o_err_count
);

  localparam int AW = WIDTH + ACCEL_LEVELS + 2;
  localparam int TW = $clog2(ACCEL_WINDOW + 1);
  localparam int LW = (ACCEL_LEVELS < 1) ? 1
                    : $clog2(ACCEL_LEVELS + 1);
  localparam int RANGE = MAX_VAL - MIN_VAL + 1;

  localparam logic [AW-1:0] MIN_X = AW'(MIN_VAL);
  localparam logic [AW-1:0] MAX_X = AW'(MAX_VAL);
  localparam logic [AW-1:0] RNG_X = AW'(RANGE);
  localparam logic [TW-1:0] WIN_T = TW'(ACCEL_WINDOW);
  localparam logic [LW-1:0] TOP_L = LW'(ACCEL_LEVELS);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [TW-1:0]    timer;
  logic [LW-1:0]    lvl;
  logic             last_dir;

  logic             fast;
  logic [LW-1:0]    lvl_nxt;
  logic [AW-1:0]    step;
  logic [AW-1:0]    cur;
  logic [AW-1:0]    up;
  logic [AW-1:0]    nxt_x;
  logic [WIDTH-1:0] val_nxt;
  logic [TW-1:0]    timer_inc;

  assign fast = (timer < WIN_T);
  assign timer_inc = (timer == WIN_T) ? timer
                   : timer + TW'(1);

  always_comb begin
    lvl_nxt = '0;
    if (fast && (i_cnt_cw == last_dir)) begin
      lvl_nxt = (lvl == TOP_L) ? lvl : lvl + LW'(1);
    end
    step  = AW'(1) << lvl_nxt;
    cur   = AW'(o_value);
    up    = cur + step;
    nxt_x = cur;
    if (i_cnt_cw) begin
      if (up > MAX_X) begin
        nxt_x = (WRAP != 0) ? up - RNG_X : MAX_X;
      end else begin
        nxt_x = up;
      end
    end else begin
      // Compare before subtracting so nothing goes negative.
      if (cur < MIN_X + step) begin
        nxt_x = (WRAP != 0) ? cur + RNG_X - step : MIN_X;
      end else begin
        nxt_x = cur - step;
      end
    end
    val_nxt = WIDTH'(nxt_x);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      o_value     <= MIN_V;
      o_changed   <= 1'b0;
      o_err_count <= '0;
      lvl         <= '0;
      timer       <= WIN_T;
      last_dir    <= 1'b1;
    end else begin
      o_changed <= 1'b0;
      timer     <= timer_inc;
      if (i_clear) begin
        o_value     <= MIN_V;
        o_changed   <= (o_value != MIN_V);
        o_err_count <= '0;
        lvl         <= '0;
        timer       <= WIN_T;
      end else if (i_cnt_err) begin
        if (!(&o_err_count)) begin
          o_err_count <= o_err_count + ERR_WIDTH'(1);
        end
        lvl   <= '0;
        timer <= WIN_T;
      end else if (i_cnt) begin
        o_value   <= val_nxt;
        o_changed <= (val_nxt != o_value);
        lvl       <= lvl_nxt;
        last_dir  <= i_cnt_cw;
        timer     <= '0;
      end
    end
  end

  assign o_at_limit = (o_value == MIN_V) || (o_value == MAX_V);

endmodule

// File: tb/tb_rotary_accumulator.sv
// Scoreboarded bench for rotary_accumulator across four parameter sets.
// Driver pushes model expectations; monitor pops and compares each cycle.
module tb_rotary_accumulator;

  localparam int N = 4;
  localparam int WIN = 40;
  localparam int P_MIN [N] = '{0, 0, 0, 5};
  localparam int P_MAX [N] = '{255, 9, 9, 100};
  localparam int P_WRP [N] = '{1, 1, 0, 0};
  localparam int P_LVL [N] = '{3, 3, 3, 2};
  localparam int P_EW  [N] = '{4, 4, 4, 3};

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic i_cnt = 1'b0;
  logic i_cnt_cw = 1'b1;
  logic i_cnt_err = 1'b0;
  logic i_clear = 1'b0;

  logic [7:0] v0, v1, v2, v3;
  logic c0, c1, c2, c3;
  logic l0, l1, l2, l3;
  logic [3:0] e0, e1, e2;
  logic [2:0] e3;

  always #5 CLK = ~CLK;

  rotary_accumulator #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(255),
    .WRAP(1), .ACCEL_WINDOW(WIN), .ACCEL_LEVELS(3), .ERR_WIDTH(4))
  u0 (.CLK(CLK), .RST_N(RST_N), .i_cnt(i_cnt), .i_cnt_cw(i_cnt_cw),
    .i_cnt_err(i_cnt_err), .i_clear(i_clear), .o_value(v0),
    .o_changed(c0), .o_at_limit(l0), .o_err_count(e0));

  rotary_accumulator #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(9),
    .WRAP(1), .ACCEL_WINDOW(WIN), .ACCEL_LEVELS(3), .ERR_WIDTH(4))
  u1 (.CLK(CLK), .RST_N(RST_N), .i_cnt(i_cnt), .i_cnt_cw(i_cnt_cw),
    .i_cnt_err(i_cnt_err), .i_clear(i_clear), .o_value(v1),
    .o_changed(c1), .o_at_limit(l1), .o_err_count(e1));

  rotary_accumulator #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(9),
    .WRAP(0), .ACCEL_WINDOW(WIN), .ACCEL_LEVELS(3), .ERR_WIDTH(4))
  u2 (.CLK(CLK), .RST_N(RST_N), .i_cnt(i_cnt), .i_cnt_cw(i_cnt_cw),
    .i_cnt_err(i_cnt_err), .i_clear(i_clear), .o_value(v2),
    .o_changed(c2), .o_at_limit(l2), .o_err_count(e2));

  rotary_accumulator #(.WIDTH(8), .MIN_VAL(5), .MAX_VAL(100),
    .WRAP(0), .ACCEL_WINDOW(WIN), .ACCEL_LEVELS(2), .ERR_WIDTH(3))
  u3 (.CLK(CLK), .RST_N(RST_N), .i_cnt(i_cnt), .i_cnt_cw(i_cnt_cw),
    .i_cnt_err(i_cnt_err), .i_clear(i_clear), .o_value(v3),
    .o_changed(c3), .o_at_limit(l3), .o_err_count(e3));

  logic [N-1:0][7:0] act_v;
  logic [N-1:0]      act_ch;
  logic [N-1:0]      act_lim;
  logic [N-1:0][3:0] act_ec;

  assign act_v   = {v3, v2, v1, v0};
  assign act_ch  = {c3, c2, c1, c0};
  assign act_lim = {l3, l2, l1, l0};
  assign act_ec  = {{1'b0, e3}, e2, e1, e0};

  typedef struct packed {
    logic [N-1:0][7:0] v;
    logic [N-1:0]      ch;
    logic [N-1:0]      lim;
    logic [N-1:0][3:0] ec;
  } exp_t;

  exp_t sq[$];
  int checks = 0;
  int failures = 0;

  // Reference state: position, accel level, cycles since last
  // accepted detent (capped at WIN), previous direction, errors.
  int m_val [N];
  int m_lvl [N];
  int m_gap [N];
  int m_ec  [N];
  bit m_dir [N];
  bit m_ch  [N];

  function automatic void cmp(string nm, int i, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, i, act, exp);
    end
  endfunction

  task automatic model(input int i, input bit rst, input bit cnt,
                       input bit cw, input bit err, input bit clr);
    int prev;
    int rng;
    int t;
    prev = m_val[i];
    rng  = P_MAX[i] - P_MIN[i] + 1;
    m_ch[i] = 1'b0;
    if (rst) begin
      m_val[i] = P_MIN[i];
      m_lvl[i] = 0;
      m_gap[i] = WIN;
      m_ec[i]  = 0;
      m_dir[i] = 1'b1;
    end else if (clr) begin
      m_val[i] = P_MIN[i];
      m_lvl[i] = 0;
      m_gap[i] = WIN;
      m_ec[i]  = 0;
      m_ch[i]  = (prev != P_MIN[i]);
    end else if (err) begin
      if (m_ec[i] < (1 << P_EW[i]) - 1) m_ec[i]++;
      m_lvl[i] = 0;
      m_gap[i] = WIN;
    end else if (cnt) begin
      if (m_gap[i] < WIN && cw == m_dir[i]) begin
        if (m_lvl[i] < P_LVL[i]) m_lvl[i]++;
      end else begin
        m_lvl[i] = 0;
      end
      if (cw) begin
        t = prev + (1 << m_lvl[i]);
        if (t > P_MAX[i]) t = P_WRP[i] != 0 ? t - rng : P_MAX[i];
      end else begin
        t = prev - (1 << m_lvl[i]);
        if (t < P_MIN[i]) t = P_WRP[i] != 0 ? t + rng : P_MIN[i];
      end
      m_val[i] = t;
      m_ch[i]  = (t != prev);
      m_dir[i] = cw;
      m_gap[i] = 0;
    end else begin
      if (m_gap[i] < WIN) m_gap[i]++;
    end
  endtask

  task automatic cyc(input bit rst, input bit cnt, input bit cw,
                     input bit err, input bit clr);
    exp_t e;
    @(negedge CLK);
    RST_N = !rst;
    i_cnt = cnt;
    i_cnt_cw = cw;
    i_cnt_err = err;
    i_clear = clr;
    e = '0;
    for (int i = 0; i < N; i++) begin
      model(i, rst, cnt, cw, err, clr);
      e.v[i]   = 8'(m_val[i]);
      e.ch[i]  = m_ch[i];
      e.lim[i] = (m_val[i] == P_MIN[i]) || (m_val[i] == P_MAX[i]);
      e.ec[i]  = 4'(m_ec[i]);
    end
    sq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 1, 0, 0);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic slow(input bit cw);
    cyc(0, 1, cw, 0, 0);
    settle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        for (int i = 0; i < N; i++) begin
          cmp("value", i, int'(act_v[i]), int'(e.v[i]));
          cmp("changed", i, int'(act_ch[i]), int'(e.ch[i]));
          cmp("at_limit", i, int'(act_lim[i]), int'(e.lim[i]));
          cmp("err_count", i, int'(act_ec[i]), int'(e.ec[i]));
        end
      end
    end
  end

  initial begin : driver
    bit dir;
    int r;
    bit rst, clr, err, cnt;
    for (int i = 0; i < N; i++) begin
      m_val[i] = 0; m_lvl[i] = 0; m_gap[i] = WIN;
      m_ec[i] = 0; m_dir[i] = 1'b1; m_ch[i] = 1'b0;
    end
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    settle();
    cmp("reset_value", 0, int'(v0), 0);
    cmp("reset_value", 3, int'(v3), 5);
    cmp("reset_err", 0, int'(e0), 0);

    for (int k = 0; k < 3; k++) begin
      idle(45);
      slow(1);
      cmp("slow_changed", 0, int'(c0), 1);
    end
    cmp("slow_cw3", 0, int'(v0), 3);

    cyc(0, 0, 1, 0, 1);
    idle(45);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 1, 0, 0);
      idle(9);
    end
    settle();
    cmp("fast_cw5", 0, int'(v0), 23);

    cyc(0, 0, 1, 0, 1);
    idle(45);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0);
      idle(9);
    end
    settle();
    cmp("fast_cw3", 0, int'(v0), 7);
    cyc(0, 1, 0, 0, 0);
    settle();
    cmp("reverse_ccw", 0, int'(v0), 6);

    cyc(0, 0, 1, 0, 1);
    for (int k = 0; k < 9; k++) begin
      idle(45);
      slow(1);
    end
    cmp("wrap_pre", 1, int'(v1), 9);
    cmp("sat_pre", 2, int'(v2), 9);
    idle(45);
    slow(1);
    cmp("wrap_cw", 1, int'(v1), 0);
    cmp("wrap_cw_changed", 1, int'(c1), 1);
    cmp("sat_cw", 2, int'(v2), 9);
    cmp("sat_cw_changed", 2, int'(c2), 0);
    cmp("sat_at_limit", 2, int'(l2), 1);
    idle(45);
    slow(0);
    cmp("wrap_ccw", 1, int'(v1), 9);
    cmp("wrap_ccw_changed", 1, int'(c1), 1);

    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 1, 0);
    settle();
    cmp("err_sat", 0, int'(e0), 15);
    cmp("err_sat", 3, int'(e3), 7);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 1);
    settle();
    cmp("clear_value", 0, int'(v0), 0);
    cmp("clear_err", 0, int'(e0), 0);
    cmp("clear_value", 3, int'(v3), 5);

    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 1, 0, 0);
      idle(3);
    end
    cyc(1, 1, 1, 1, 0);
    settle();
    cmp("midspin_reset", 0, int'(v0), 0);
    cmp("midspin_reset", 3, int'(v3), 5);
    slow(1);
    cmp("post_reset_step", 0, int'(v0), 1);

    dir = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r   = $urandom_range(0, 999);
      rst = (r < 5);
      clr = (r >= 5) && (r < 20);
      err = (r >= 20) && (r < 50);
      cnt = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      cyc(rst, cnt, dir, err, clr);
      if ($urandom_range(0, 59) == 0) idle(45);
    end
    idle(2);
    settle();
    settle();
    cmp("queue_drained", 0, sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
